// File: rtl/cas_write_seq.sv
// ----------------------------------------------------------------------------
// cas_write_seq -- cassette-write sequencer for the EG2000 tape output path.
//
// Buffers CPU bytes in a small FIFO and frames each block on tape as
//   motor spin-up -> LEADER_LEN x LEADER_BYTE -> SYNC_BYTE -> data -> stop.
// Bytes are handed one at a time to the byte-level tone generator with a
// start/din/done handshake. The generator's done flag is asynchronous and is
// resynchronized here before use.
//
// Optional feature (compile-time macro CAS_CHECKSUM_EN):
//   when defined, an 8-bit modulo-256 sum of the data bytes (filler excluded)
//   is sent as one extra byte after the data and before stop.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   wr_en, wr_data    push a byte into the FIFO (dropped when full)
//   full, fifo_level  FIFO status, registered
//   blk_go            one-cycle pulse, starts a block (ignored unless idle)
//   blk_end           one-cycle pulse, no more data for this block
//   busy              high while a block is in progress
//   underrun          sticky, set when a filler byte had to be sent
//   bytes_sent        data bytes sent in the current block (wraps)
//   motor             tape motor relay enable
//   gen_start         one-cycle start pulse to the tone generator
//   gen_din           byte for the generator, held until its done
//   gen_done          generator done flag (asynchronous)
// ----------------------------------------------------------------------------
module cas_write_seq #(
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [15:0] LEADER_LEN  = 16'd256,
  parameter logic [7:0]  LEADER_BYTE = 8'hAA,
  parameter logic [7:0]  SYNC_BYTE   = 8'h66,
  parameter logic [23:0] MOTOR_DLY   = 24'd16000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic [FIFO_AW:0]   fifo_level,
  input  logic               blk_go,
  input  logic               blk_end,
  output logic               busy,
  output logic               underrun,
  output logic [15:0]        bytes_sent,
  output logic               motor,
  output logic               gen_start,
  output logic [7:0]         gen_din,
  input  logic               gen_done
);

  localparam int unsigned     DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_LEADER,
    ST_SYNC,
    ST_DATA,
`ifdef CAS_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_STOP
  } state_t;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_START,
    SB_LOW,
    SB_HIGH
  } sb_state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  logic               r_done_s1;
  logic               r_done_s2;
  logic               w_dsync;

  state_t             r_state;
  state_t             w_next_state;
  sb_state_t          r_sb_state;
  sb_state_t          w_sb_next;

  logic [23:0]        r_cnt;
  logic [15:0]        r_bytes_sent;
  logic               r_underrun;
  logic               r_end_latch;
  logic               r_gen_start;
  logic [7:0]         r_gen_din;
`ifdef CAS_CHECKSUM_EN
  logic [7:0]         r_sum;
`endif

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_accept_go;
  logic               w_sending;
  logic               w_boundary;
  logic               w_in_data;
  logic               w_filler;
  logic               w_data_end;
  logic               w_send_req;
  logic [7:0]         w_send_byte;
  logic               w_byte_done;
  logic               w_motor_last;
  logic               w_leader_last;

  // --------------------------------------------------------------------------
  // gen_done synchronizer
  // --------------------------------------------------------------------------
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_s1 <= 1'b0;
      r_done_s2 <= 1'b0;
    end else begin
      r_done_s1 <= gen_done;
      r_done_s2 <= r_done_s1;
    end
  end

  assign w_dsync = r_done_s2;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_L);
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign w_push  = wr_en && (!w_full || w_pop);

  // NOTE: the storage array has no reset; only the pointers and count are
  // cleared, which is enough to make the contents unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full       = w_full;
  assign fifo_level = r_count;

  // --------------------------------------------------------------------------
  // Main FSM decode
  // --------------------------------------------------------------------------
  assign w_accept_go = (r_state == ST_IDLE) && blk_go;
  assign w_byte_done = (r_sb_state == SB_HIGH);

  always_comb begin
    // NOTE: every combinationally driven signal gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    w_sending = 1'b0;
    case (r_state)
      ST_LEADER, ST_SYNC, ST_DATA: w_sending = 1'b1;
`ifdef CAS_CHECKSUM_EN
      ST_CKSUM:                    w_sending = 1'b1;
`endif
      default:                     w_sending = 1'b0;
    endcase
  end

  // A byte boundary is any cycle in a sending state with the byte sender idle.
  assign w_boundary = w_sending && (r_sb_state == SB_IDLE);
  assign w_in_data  = w_boundary && (r_state == ST_DATA);
  // Data boundary priority: queued byte, then end of block, then filler.
  assign w_pop      = w_in_data && !w_empty;
  assign w_data_end = w_in_data && w_empty && r_end_latch;
  assign w_filler   = w_in_data && w_empty && !r_end_latch;
  assign w_send_req = w_boundary && !w_data_end;

  always_comb begin
    w_send_byte = LEADER_BYTE;
    case (r_state)
      ST_SYNC:  w_send_byte = SYNC_BYTE;
      ST_DATA:  w_send_byte = w_empty ? LEADER_BYTE : r_mem[r_rd_ptr];
`ifdef CAS_CHECKSUM_EN
      ST_CKSUM: w_send_byte = r_sum;
`endif
      default:  w_send_byte = LEADER_BYTE;
    endcase
  end

  // Extra bit of headroom so MOTOR_DLY / LEADER_LEN at their maximum cannot
  // wrap the "+1" compare.
  assign w_motor_last  = ({1'b0, r_cnt} + 25'd1) >= {1'b0, MOTOR_DLY};
  assign w_leader_last = ({1'b0, r_cnt[15:0]} + 17'd1) >= {1'b0, LEADER_LEN};

  // --------------------------------------------------------------------------
  // Main FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (blk_go) begin
          w_next_state = ST_MOTOR;
        end
      end
      ST_MOTOR: begin
        if (w_motor_last) begin
          w_next_state = (LEADER_LEN == 16'd0) ? ST_SYNC : ST_LEADER;
        end
      end
      ST_LEADER: begin
        if (w_byte_done && w_leader_last) begin
          w_next_state = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (w_byte_done) begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_data_end) begin
`ifdef CAS_CHECKSUM_EN
          w_next_state = ST_CKSUM;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
`ifdef CAS_CHECKSUM_EN
      ST_CKSUM: begin
        if (w_byte_done) begin
          w_next_state = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    motor = 1'b0;
    case (r_state)
      ST_IDLE, ST_STOP: begin
        busy  = 1'b0;
        motor = 1'b0;
      end
      default: begin
        busy  = 1'b1;
        motor = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Main FSM datapath: phase counter, block status, checksum
  // --------------------------------------------------------------------------
  // r_cnt counts motor cycles in MOTOR and leader bytes in LEADER; it is
  // cleared on every state change so each phase starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != w_next_state) begin
      r_cnt <= '0;
    end else if ((r_state == ST_MOTOR) ||
                 ((r_state == ST_LEADER) && w_byte_done)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bytes_sent <= '0;
      r_underrun   <= 1'b0;
      r_end_latch  <= 1'b0;
    end else if (w_accept_go) begin
      r_bytes_sent <= '0;
      r_underrun   <= 1'b0;
      r_end_latch  <= 1'b0;
    end else begin
      if (busy && blk_end) begin
        r_end_latch <= 1'b1;
      end
      if (w_pop) begin
        r_bytes_sent <= r_bytes_sent + 1'b1;
      end
      if (w_filler) begin
        r_underrun <= 1'b1;
      end
    end
  end

`ifdef CAS_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_accept_go) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + r_mem[r_rd_ptr];
    end
  end
`endif

  assign bytes_sent = r_bytes_sent;
  assign underrun   = r_underrun;

  // --------------------------------------------------------------------------
  // Byte-send sub-FSM: state register / next state / generator outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_state <= SB_IDLE;
    end else begin
      r_sb_state <= w_sb_next;
    end
  end

  // START waits for the generator to acknowledge (done low), LOW waits for it
  // to finish (done high); HIGH is the one-cycle byte-complete report.
  always_comb begin
    w_sb_next = r_sb_state;
    case (r_sb_state)
      SB_IDLE:  if (w_send_req) w_sb_next = SB_START;
      SB_START: if (!w_dsync)   w_sb_next = SB_LOW;
      SB_LOW:   if (w_dsync)    w_sb_next = SB_HIGH;
      SB_HIGH:                  w_sb_next = SB_IDLE;
      default:                  w_sb_next = SB_IDLE;
    endcase
  end

  // gen_din is only reloaded with a new start, so it stays put while the
  // generator is shifting the byte out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen_start <= 1'b0;
      r_gen_din   <= '0;
    end else begin
      r_gen_start <= w_send_req;
      if (w_send_req) begin
        r_gen_din <= w_send_byte;
      end
    end
  end

  assign gen_start = r_gen_start;
  assign gen_din   = r_gen_din;

endmodule

// File: tb/tb_cas_write_seq.sv
// ----------------------------------------------------------------------------
// tb_cas_write_seq -- self-checking bench for cas_write_seq.
//
// A tone-generator model answers every gen_start by holding gen_done low for
// 50 cycles. Expected generator bytes are queued as stimulus is written and
// compared as each gen_start appears. Build with +define+CAS_CHECKSUM_EN to
// expect the checksum byte.
// ----------------------------------------------------------------------------
module tb_cas_write_seq;

  localparam int unsigned FIFO_AW     = 4;
  localparam logic [15:0] LEADER_LEN  = 16'd4;
  localparam logic [7:0]  LEADER_BYTE = 8'hAA;
  localparam logic [7:0]  SYNC_BYTE   = 8'h66;
  localparam logic [23:0] MOTOR_DLY   = 24'd10;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic [FIFO_AW:0] fifo_level;
  logic             blk_go;
  logic             blk_end;
  logic             busy;
  logic             underrun;
  logic [15:0]      bytes_sent;
  logic             motor;
  logic             gen_start;
  logic [7:0]       gen_din;
  logic             gen_done;

  cas_write_seq #(
    .FIFO_AW    (FIFO_AW),
    .LEADER_LEN (LEADER_LEN),
    .LEADER_BYTE(LEADER_BYTE),
    .SYNC_BYTE  (SYNC_BYTE),
    .MOTOR_DLY  (MOTOR_DLY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .fifo_level(fifo_level),
    .blk_go    (blk_go),
    .blk_end   (blk_end),
    .busy      (busy),
    .underrun  (underrun),
    .bytes_sent(bytes_sent),
    .motor     (motor),
    .gen_start (gen_start),
    .gen_din   (gen_din),
    .gen_done  (gen_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and counters
  logic [7:0] exp_q[$];
  logic [7:0] sum_acc;
  logic [7:0] exp_b;
  int         n_cmp    = 0;
  int         n_err    = 0;
  int         n_starts = 0;

  // Generator model state
  int         gen_cnt;
  int         since_rise;
  logic       in_flight;
  logic       din_moved;
  logic [7:0] cap_din;

  // Generator model plus byte monitor, all evaluated on the falling edge.
  initial begin
    gen_done   = 1'b1;
    gen_cnt    = 0;
    since_rise = 1000;
    in_flight  = 1'b0;
    din_moved  = 1'b0;
    cap_din    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gen_done   = 1'b1;
        gen_cnt    = 0;
        since_rise = 1000;
        in_flight  = 1'b0;
        din_moved  = 1'b0;
      end else if (gen_start) begin
        n_starts++;
        n_cmp++;
        if (in_flight) begin
          n_err++;
          $display("FAIL start_per_byte: gen_start seen while byte 0x%02h still in flight, required none", cap_din);
        end
        n_cmp++;
        if (since_rise < 2) begin
          n_err++;
          $display("FAIL start_spacing: start %0d edges after done rose, required >= 2", since_rise);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL gen_din_seq: unexpected byte 0x%02h, required no byte", gen_din);
        end else begin
          exp_b = exp_q.pop_front();
          if (gen_din !== exp_b) begin
            n_err++;
            $display("FAIL gen_din_seq: got 0x%02h, required 0x%02h", gen_din, exp_b);
          end
        end
        cap_din   = gen_din;
        in_flight = 1'b1;
        din_moved = 1'b0;
        gen_done  = 1'b0;
        gen_cnt   = 50;
      end else begin
        if (in_flight && (gen_din !== cap_din)) din_moved = 1'b1;
        if (gen_cnt > 0) begin
          gen_cnt--;
          if (gen_cnt == 0) begin
            gen_done = 1'b1;
            n_cmp++;
            if (din_moved) begin
              n_err++;
              $display("FAIL din_stable: gen_din changed before done for byte 0x%02h, required stable", cap_din);
            end
            in_flight  = 1'b0;
            since_rise = 0;
          end
        end else if (since_rise < 1000) begin
          since_rise++;
        end
      end
    end
  end

  // Watchdog: the bench must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all start and end on a falling edge)
  // --------------------------------------------------------------------------
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_go();
    blk_go = 1'b1;
    @(negedge clk);
    blk_go = 1'b0;
  endtask

  task automatic pulse_end();
    blk_end = 1'b1;
    @(negedge clk);
    blk_end = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < int'(LEADER_LEN); i++) exp_q.push_back(LEADER_BYTE);
    exp_q.push_back(SYNC_BYTE);
    sum_acc = '0;
  endtask

  task automatic push_data(input logic [7:0] b);
    exp_q.push_back(b);
    sum_acc = sum_acc + b;
  endtask

  task automatic push_tail();
`ifdef CAS_CHECKSUM_EN
    exp_q.push_back(sum_acc);
`endif
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy) begin
      n_err++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", tag, budget);
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while ((n_starts < target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (n_starts < target) begin
      n_err++;
      $display("FAIL %s_timeout: %0d starts seen, required %0d", tag, n_starts, target);
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (full !== 1'b0)       begin n_err++; $display("FAIL rst_full: got %b, required 0", full); end
    n_cmp++; if (fifo_level !== '0)   begin n_err++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_cmp++; if (underrun !== 1'b0)   begin n_err++; $display("FAIL rst_underrun: got %b, required 0", underrun); end
    n_cmp++; if (bytes_sent !== '0)   begin n_err++; $display("FAIL rst_bytes: got %0d, required 0", bytes_sent); end
    n_cmp++; if (motor !== 1'b0)      begin n_err++; $display("FAIL rst_motor: got %b, required 0", motor); end
    n_cmp++; if (gen_start !== 1'b0)  begin n_err++; $display("FAIL rst_start: got %b, required 0", gen_start); end
    n_cmp++; if (gen_din !== 8'h00)   begin n_err++; $display("FAIL rst_din: got 0x%02h, required 0x00", gen_din); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_framing();
    int base;
    int k;
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    n_cmp++; if (fifo_level !== 5'd3) begin n_err++; $display("FAIL frm_level: got %0d, required 3", fifo_level); end
    push_frame();
    push_data(8'h01); push_data(8'h02); push_data(8'h03);
    push_tail();
    base = n_starts;
    pulse_go();
    n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL frm_busy: got %b, required 1", busy); end
    n_cmp++; if (motor !== 1'b1) begin n_err++; $display("FAIL frm_motor_on: got %b, required 1", motor); end
    pulse_end();
    k = 1;
    while ((n_starts == base) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if ((n_starts == base) || (k < int'(MOTOR_DLY))) begin
      n_err++;
      $display("FAIL frm_latency: first start after %0d cycles, required >= %0d", k, MOTOR_DLY);
    end
    // A second blk_go mid-block must be ignored.
    wait_starts(base + 2, 500, "frm_mid");
    pulse_go();
    wait_idle(3000, "frm");
    n_cmp++; if (motor !== 1'b0)         begin n_err++; $display("FAIL frm_motor_off: got %b, required 0", motor); end
    n_cmp++; if (bytes_sent !== 16'd3)   begin n_err++; $display("FAIL frm_bytes: got %0d, required 3", bytes_sent); end
    n_cmp++; if (underrun !== 1'b0)      begin n_err++; $display("FAIL frm_underrun: got %b, required 0", underrun); end
    n_cmp++; if (exp_q.size() != 0)      begin n_err++; $display("FAIL frm_all_sent: %0d bytes missing, required 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_underrun();
    int base;
    push_frame();
    exp_q.push_back(LEADER_BYTE);
    exp_q.push_back(LEADER_BYTE);
    push_data(8'h5A);
    push_tail();
    base = n_starts;
    pulse_go();
    wait_starts(base + int'(LEADER_LEN) + 3, 2000, "urn_fill");
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL urn_set: got %b, required 1", underrun); end
    write_byte(8'h5A);
    pulse_end();
    wait_idle(3000, "urn");
    n_cmp++; if (underrun !== 1'b1)     begin n_err++; $display("FAIL urn_sticky: got %b, required 1", underrun); end
    n_cmp++; if (bytes_sent !== 16'd1)  begin n_err++; $display("FAIL urn_bytes: got %0d, required 1", bytes_sent); end
    n_cmp++; if (exp_q.size() != 0)     begin n_err++; $display("FAIL urn_all_sent: %0d bytes missing, required 0", exp_q.size()); end
    @(negedge clk);
    // The next block clears underrun; blk_end up front means no filler.
    push_frame();
    push_tail();
    pulse_go();
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL urn_clear: got %b, required 0", underrun); end
    pulse_end();
    wait_idle(3000, "urn2");
    n_cmp++; if (underrun !== 1'b0)     begin n_err++; $display("FAIL urn2_flag: got %b, required 0", underrun); end
    n_cmp++; if (bytes_sent !== 16'd0)  begin n_err++; $display("FAIL urn2_bytes: got %0d, required 0", bytes_sent); end
    n_cmp++; if (exp_q.size() != 0)     begin n_err++; $display("FAIL urn2_all_sent: %0d bytes missing, required 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    push_frame();
    for (int i = 0; i < 17; i++) begin
      write_byte(8'h80 + 8'(i));
      if (i < 16) push_data(8'h80 + 8'(i));
      if (i == 14) begin
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_early: got %b at 15 entries, required 0", full); end
      end
    end
    push_tail();
    n_cmp++; if (full !== 1'b1)        begin n_err++; $display("FAIL full_flag: got %b, required 1", full); end
    n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d, required 16", fifo_level); end
    pulse_go();
    pulse_end();
    wait_idle(5000, "full");
    n_cmp++; if (bytes_sent !== 16'd16) begin n_err++; $display("FAIL full_bytes: got %0d, required 16", bytes_sent); end
    n_cmp++; if (fifo_level !== '0)     begin n_err++; $display("FAIL full_drained: got %0d, required 0", fifo_level); end
    n_cmp++; if (exp_q.size() != 0)     begin n_err++; $display("FAIL full_all_sent: %0d bytes missing, required 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    push_frame();
    push_data(8'h11);
    base = n_starts;
    pulse_go();
    pulse_end();
    wait_starts(base + int'(LEADER_LEN) + 2, 2000, "rmid");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (motor !== 1'b0)      begin n_err++; $display("FAIL rmid_motor: got %b, required 0", motor); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    n_cmp++; if (gen_start !== 1'b0)  begin n_err++; $display("FAIL rmid_start: got %b, required 0", gen_start); end
    n_cmp++; if (fifo_level !== '0)   begin n_err++; $display("FAIL rmid_level: got %0d, required 0", fifo_level); end
    n_cmp++; if (bytes_sent !== '0)   begin n_err++; $display("FAIL rmid_bytes: got %0d, required 0", bytes_sent); end
    n_cmp++; if (underrun !== 1'b0)   begin n_err++; $display("FAIL rmid_underrun: got %b, required 0", underrun); end
    n_cmp++; if (exp_q.size() != 0)   begin n_err++; $display("FAIL rmid_prefix: %0d bytes missing, required 0", exp_q.size()); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle: busy got %b, required 0", busy); end
    // A fresh block after reset: only the new data, nothing left from before.
    write_byte(8'h44);
    write_byte(8'h55);
    push_frame();
    push_data(8'h44); push_data(8'h55);
    push_tail();
    pulse_go();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_restart: busy got %b, required 1", busy); end
    pulse_end();
    wait_idle(3000, "rmid2");
    n_cmp++; if (bytes_sent !== 16'd2) begin n_err++; $display("FAIL rmid2_bytes: got %0d, required 2", bytes_sent); end
    n_cmp++; if (motor !== 1'b0)       begin n_err++; $display("FAIL rmid2_motor: got %b, required 0", motor); end
    n_cmp++; if (exp_q.size() != 0)    begin n_err++; $display("FAIL rmid2_all_sent: %0d bytes missing, required 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_checksum();
    write_byte(8'h10);
    write_byte(8'h20);
    write_byte(8'hF0);
    push_frame();
    push_data(8'h10); push_data(8'h20); push_data(8'hF0);
    push_tail();
    pulse_go();
    pulse_end();
    wait_idle(3000, "cks");
    n_cmp++; if (bytes_sent !== 16'd3) begin n_err++; $display("FAIL cks_bytes: got %0d, required 3", bytes_sent); end
    n_cmp++; if (exp_q.size() != 0)    begin n_err++; $display("FAIL cks_all_sent: %0d bytes missing, required 0", exp_q.size()); end
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    blk_go  = 1'b0;
    blk_end = 1'b0;
    sum_acc = '0;
    test_reset();
    test_framing();
    test_underrun();
    test_fifo_full();
    test_reset_mid();
    test_checksum();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cas_write_seq.md
Name: cas_write_seq

Overview:
- Cassette-write sequencer for the EG2000 tape output path.
- Buffers bytes written by the CPU-side logic in a small FIFO.
- Frames each block as motor spin-up, leader bytes, sync byte, data bytes and stop.
- Feeds the bytes one at a time to the byte-level square-wave tone generator, using its start/din/done handshake, and drives the tape motor relay.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.
- LEADER_LEN, 16'd256, number of leader bytes per block; 0 means no leader.
- LEADER_BYTE, 8'hAA, leader and underrun-filler byte value.
- SYNC_BYTE, 8'h66, sync marker sent after the leader.
- MOTOR_DLY, 24'd16000, clk cycles between motor on and the first byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  8  byte to buffer.
- full  out  1  FIFO full.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- blk_go  in  1  one-cycle pulse that starts a block.
- blk_end  in  1  one-cycle pulse meaning no more data for this block.
- busy  out  1  high from the cycle after an accepted blk_go until the block returns to IDLE.
- underrun  out  1  sticky; set when filler is sent; cleared on an accepted blk_go.
- bytes_sent  out  16  data bytes sent in the current block; wraps modulo 2^16.
- motor  out  1  motor relay enable.
- gen_start  out  1  one-cycle start pulse to the tone generator.
- gen_din  out  8  byte for the generator; stable from gen_start until that byte's done.
- gen_done  in  1  generator done flag; asynchronous to clk.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0, FIFO emptied, state IDLE, internal latches cleared. Reset mid-block abandons the current byte immediately.
- gen_done passes through a 2-flop synchronizer; the synchronized copy is called dsync.
- FIFO behaviour:
  - A write while full is dropped.
  - A write and a pop in the same cycle while full both succeed, so the level is unchanged.
  - A write and a pop in the same cycle while empty: the pop sees empty and the write lands.
  - fifo_level and full update the cycle after the write or pop.
- Byte-send sub-FSM:
  - SB_IDLE -> SB_START: gen_start=1 for exactly one cycle, gen_din loaded.
  - SB_START -> SB_LOW: wait for dsync==0.
  - SB_LOW -> SB_HIGH: wait for dsync==1, then report byte-complete and return to SB_IDLE.
  - Back-to-back bytes: the next gen_start comes no earlier than 1 cycle after byte-complete.
- Main FSM:
  - IDLE: blk_go -> MOTOR. blk_go in any other state is ignored. On an accepted blk_go: busy=1, underrun=0, bytes_sent=0, end latch=0.
  - MOTOR: motor=1, count MOTOR_DLY cycles, then go to LEADER (or SYNC if LEADER_LEN=0).
  - LEADER: send LEADER_BYTE LEADER_LEN times -> SYNC.
  - SYNC: send SYNC_BYTE once -> DATA.
  - DATA: at each byte boundary, evaluated in this order:
    - FIFO not empty: pop and send the byte, bytes_sent+1.
    - Else, end latch set: go to STOP.
    - Else: send LEADER_BYTE as filler and set underrun=1. Filler does not increment bytes_sent.
  - STOP: motor=0, busy=0 -> IDLE. Takes 1 cycle.
- blk_end: a pulse in any busy state sets the end latch. The latch does not skip leader or sync. Queued FIFO data is always drained before STOP.
- A blk_end pulse while IDLE is ignored.
- The FIFO keeps accepting writes in IDLE; that data is sent in the next block.
- If dsync is already 0 at SB_START, the sub-FSM proceeds straight to SB_LOW's wait for 1.

Optional Feature:
- Macro: CAS_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (modulo 256) of the data bytes is kept; filler bytes are excluded; the sum is cleared on blk_go.
  - When DATA would go to STOP, a CKSUM state first sends the sum byte, then goes to STOP.
  - The checksum byte does not count in bytes_sent.
- Not defined: no sum register and no CKSUM state; DATA goes directly to STOP.

Test Plan:
- Leader/sync framing: LEADER_LEN=4, MOTOR_DLY=10. Write 3 bytes 01,02,03, then blk_go, then blk_end.
  - motor=1; the first gen_start comes 10+ cycles later.
  - gen_din sequence: AA,AA,AA,AA,66,01,02,03; then motor=0, busy=0, bytes_sent=3.
- Handshake: the generator model holds done low for 50 cycles after each start.
  - Exactly one gen_start per byte.
  - gen_din stable until done rises.
  - The next start comes at least 1 cycle after the synchronized done rises.
- Underrun: blk_go with an empty FIFO, no blk_end, 2 filler bytes elapse, then write 5A and send blk_end.
  - Sequence after the sync byte: AA,AA,5A.
  - underrun=1; bytes_sent=1.
  - The next blk_go clears underrun.
- FIFO full: depth 16; write 17 bytes in IDLE.
  - full=1 and fifo_level=16.
  - The 17th byte is dropped; the block sends exactly the first 16 bytes in order.
- Reset mid-block: assert rst_n=0 during a DATA byte.
  - motor, busy, gen_start, fifo_level, bytes_sent and underrun are all 0 immediately.
  - After release, the state is IDLE and a new blk_go runs a full clean block.
- CAS_CHECKSUM_EN defined: data 10,20,F0.
  - Checksum byte 20 is sent after F0 and before motor=0.
  - bytes_sent=3.
